// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle adder/subtractor. A WIDTH-bit operand pair is
// processed CHUNK bits per cycle, LSB chunk first, with the ripple carry held
// in a register between chunks. Operands in and results out use valid/ready.
// Status flags: cout (1 = no borrow on subtract), ovf, zero, neg.
//
// Build option: define ADDSUB_SAT_EN to saturate the sum to the signed
// extreme on overflow. Without it the sum wraps modulo 2^WIDTH.
module addsub_seq #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int N    = WIDTH / CHUNK;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;        // B already inverted when subtracting
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic             accept;
    logic             last;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             msb_cin;
    logic             ovf_raw;
    logic [WIDTH-1:0] sum_merged;
    logic [WIDTH-1:0] sum_final;

    assign accept = in_valid && in_ready;
    assign last   = (idx == LAST_IDX);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from the same pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        // NOTE: every output gets a default before the case, otherwise an
        // uncovered path would infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // One chunk of the ripple add, merged into the running sum; on the last
    // chunk also derive overflow and (optionally) the saturated result.
    always_comb begin
        a_chunk = a_q[int'(idx) * CHUNK +: CHUNK];
        b_chunk = b_q[int'(idx) * CHUNK +: CHUNK];
        {chunk_cout, chunk_sum} = {1'b0, a_chunk} + {1'b0, b_chunk}
                                + {{CHUNK{1'b0}}, carry};
        // Carry into the top bit of this chunk, recovered from the sum bit.
        msb_cin = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
        ovf_raw = msb_cin ^ chunk_cout;
        sum_merged = sum;
        sum_merged[int'(idx) * CHUNK +: CHUNK] = chunk_sum;
        sum_final = sum_merged;
`ifdef ADDSUB_SAT_EN
        // A wrapped negative result means the true result was positive.
        if (last && ovf_raw) begin
            sum_final = sum_merged[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                            : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    // Operand capture on accept.
    always_ff @(posedge clk) begin
        // NOTE: operand registers have no reset; they are always loaded on
        // accept before RUN reads them, so their power-up value never matters.
        if (accept) begin
            a_q <= a;
            b_q <= op ? ~b : b;
        end
    end

    // Carry, chunk index, result and flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            zero  <= 1'b0;
            neg   <= 1'b0;
        end else if (accept) begin
            carry <= op;
            idx   <= '0;
        end else if (state == RUN) begin
            sum   <= sum_final;
            carry <= chunk_cout;
            idx   <= idx + IDXW'(1);
            if (last) begin
                cout <= chunk_cout;
                ovf  <= ovf_raw;
                zero <= (sum_final == '0);
                neg  <= sum_final[WIDTH-1];
            end
        end
    end

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (WIDTH 16, CHUNK 4). Stimulus pushes hand-computed
// results into a queue; an independent monitor pops one entry per output
// transfer and compares it. Expectations follow ADDSUB_SAT_EN when defined.
module tb_addsub_seq;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int N     = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             neg;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pushed = 0;
    int   n_popped = 0;

    always #5 clk = ~clk;

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .neg       (neg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input logic v,
                                input logic z, input logic n);
        return {s, c, v, z, n};
    endfunction

    // Monitor: one pop per output transfer (valid and ready both high).
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_popped++;
                check($sformatf("result%0d sum", n_popped), sum, e.sum);
                check($sformatf("result%0d cout", n_popped), cout, e.cout);
                check($sformatf("result%0d ovf", n_popped), ovf, e.ovf);
                check($sformatf("result%0d zero", n_popped), zero, e.zero);
                check($sformatf("result%0d neg", n_popped), neg, e.neg);
            end
        end
    end

    // Issue one operation, push its expected result, and measure latency.
    // With pulse set, in_valid is raised with junk operands during RUN.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic iop, input exp_t e, input bit pulse);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            check("in_ready timeout", 32'd0, 32'd1);
            return;
        end
        exp_q.push_back(e);
        n_pushed++;
        #1;
        a        = ia;
        b        = ib;
        op       = iop;
        in_valid = 1'b1;
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            #1;
            if (pulse) begin
                in_valid = (lat == 1);
                a        = 16'hFFFF;
                b        = 16'hFFFF;
                op       = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, N);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required test end");
        $fatal(1);
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 0);
        check("reset sum", sum, 0);
        check("reset flags", {cout, ovf, zero, neg}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready after reset", in_ready, 1);

        // Basic add and subtract cases.
        issue(16'h1234, 16'h0FF0, 1'b0, mk(16'h2224, 0, 0, 0, 0), 0);
        issue(16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 0, 0, 0, 1), 0);
        issue(16'h1234, 16'h1234, 1'b1, mk(16'h0000, 1, 0, 1, 0), 0);
`ifdef ADDSUB_SAT_EN
        issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h7FFF, 0, 1, 0, 0), 0);
        issue(16'h8000, 16'h0001, 1'b1, mk(16'h8000, 1, 1, 0, 1), 0);
        issue(16'h8000, 16'h8000, 1'b0, mk(16'h8000, 1, 1, 0, 1), 0);
`else
        issue(16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0, 1), 0);
        issue(16'h8000, 16'h0001, 1'b1, mk(16'h7FFF, 1, 1, 0, 0), 0);
        issue(16'h8000, 16'h8000, 1'b0, mk(16'h0000, 1, 1, 1, 0), 0);
`endif

        // Backpressure: result held for 3 cycles with out_ready low.
        @(negedge clk);
        #1 out_ready = 1'b0;
        issue(16'h00FF, 16'h0001, 1'b0, mk(16'h0100, 0, 0, 0, 0), 0);
        repeat (3) begin
            @(negedge clk);
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
            check("hold sum", sum, 16'h0100);
            check("hold flags", {cout, ovf, zero, neg}, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;

        // in_valid pulsed during RUN with other operands must be ignored.
        issue(16'hFFFF, 16'h0001, 1'b0, mk(16'h0000, 1, 0, 1, 0), 1);

        // Reset after two chunks of a run: abort, no result.
        @(negedge clk);
        check("in_ready before abort", in_ready, 1);
        #1;
        a        = 16'h1111;
        b        = 16'h2222;
        op       = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort out_valid", out_valid, 0);
        check("abort sum", sum, 0);
        check("abort in_ready during rst", in_ready, 0);
        check("abort flags", {cout, ovf, zero, neg}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready after abort", in_ready, 1);
        check("out_valid after abort", out_valid, 0);
        issue(16'h0001, 16'h0001, 1'b0, mk(16'h0002, 0, 0, 0, 0), 0);

        repeat (3) @(negedge clk);
        check("results transferred", n_popped, n_pushed);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
